// File: rtl/gate_sensor_interface.sv
// Two-lane beam-sensor front end: synchronise and debounce raw beams, then
// sequence-check each lane and pulse once per completed legal passage.
package gate_sensor_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_A_ON,
        ST_BOTH,
        ST_B_ONLY,
        ST_REVERSE,
        ST_FAULT
    } lane_state_t;
endpackage

// 2-flop synchroniser followed by a saturating-free debounce counter.
module gate_sensor_filter #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level
);
    // The update fires on the cycle the counter would reach DEBOUNCE_CYCLES.
    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic       sync1;
    logic       sync2;
    logic [7:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= 8'd0;
            level <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= 8'd0;
            end else if (cnt == DB_LAST) begin
                level <= sync2;
                cnt   <= 8'd0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end
endmodule

// One lane: conditioning for both beams plus the passage sequence FSM.
module gate_sensor_lane
    import gate_sensor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        a_raw,
    input  logic        b_raw,
    output logic        passed,
    output logic        fault,
    output lane_state_t state
);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic        a;
    logic        b;
    logic [15:0] tcnt;
    logic        timed;
    logic        timed_out;
    lane_state_t next_state;

    gate_sensor_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filt_a (
        .clk(clk), .reset_n(reset_n), .raw(a_raw), .level(a)
    );
    gate_sensor_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filt_b (
        .clk(clk), .reset_n(reset_n), .raw(b_raw), .level(b)
    );

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (b)      next_state = ST_REVERSE;
                else if (a) next_state = ST_A_ON;
            end
            ST_A_ON: begin
                if (a && b)      next_state = ST_BOTH;
                else if (b)      next_state = ST_B_ONLY;
                else if (!a)     next_state = ST_IDLE;
            end
            ST_BOTH: begin
                if (!a && b)      next_state = ST_B_ONLY;
                else if (a && !b) next_state = ST_A_ON;
                else if (!a)      next_state = ST_IDLE;
            end
            ST_B_ONLY: begin
                if (!a && !b)    next_state = ST_IDLE;
                else if (a && b) next_state = ST_BOTH;
                else if (a)      next_state = ST_A_ON;
            end
            ST_REVERSE, ST_FAULT: begin
                if (!a && !b) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // A pending state change always beats the timeout on the same cycle.
    assign timed     = (state == ST_A_ON) || (state == ST_BOTH) ||
                       (state == ST_B_ONLY) || (state == ST_REVERSE);
    assign timed_out = timed && (next_state == state) && (tcnt == TO_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            tcnt   <= 16'd0;
            passed <= 1'b0;
        end else begin
            passed <= (state == ST_B_ONLY) && (next_state == ST_IDLE);
            if (timed_out) begin
                state <= ST_FAULT;
                tcnt  <= 16'd0;
            end else if (next_state != state) begin
                state <= next_state;
                tcnt  <= 16'd0;
            end else if (timed) begin
                tcnt <= tcnt + 16'd1;
            end else begin
                tcnt <= 16'd0;
            end
        end
    end

    // Fault drops as soon as both filtered beams read clear, i.e. in the
    // same cycle the FSM decides to return to IDLE.
    assign fault = (state == ST_FAULT) && (a || b);
endmodule

module gate_sensor_interface
    import gate_sensor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic entry_a_raw,
    input  logic entry_b_raw,
    input  logic exit_a_raw,
    input  logic exit_b_raw,
    output logic entry_passed,
    output logic exit_passed,
    output logic entry_busy,
    output logic exit_busy,
    output logic entry_fault,
    output logic exit_fault
);
    lane_state_t entry_state;
    lane_state_t exit_state;

    gate_sensor_lane #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_entry (
        .clk    (clk),
        .reset_n(reset_n),
        .a_raw  (entry_a_raw),
        .b_raw  (entry_b_raw),
        .passed (entry_passed),
        .fault  (entry_fault),
        .state  (entry_state)
    );

    gate_sensor_lane #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_exit (
        .clk    (clk),
        .reset_n(reset_n),
        .a_raw  (exit_a_raw),
        .b_raw  (exit_b_raw),
        .passed (exit_passed),
        .fault  (exit_fault),
        .state  (exit_state)
    );

    assign entry_busy = (entry_state != ST_IDLE);
    assign exit_busy  = (exit_state != ST_IDLE);
endmodule

// File: tb/tb_gate_sensor_interface.sv
// Bench for gate_sensor_interface: directed beam sequences, pulse cycles
// predicted by the driver and checked by an independent monitor.
module tb_gate_sensor_interface;
    localparam int DB = 4;
    localparam int TO = 50;
    // Raw edge to passed pulse: 2 sync + DB debounce + 1 registered output.
    localparam int PULSE_LAT = 2 + DB + 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic entry_a_raw = 1'b0, entry_b_raw = 1'b0;
    logic exit_a_raw = 1'b0, exit_b_raw = 1'b0;
    logic entry_passed, exit_passed, entry_busy, exit_busy, entry_fault, exit_fault;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_entry_q[$];
    logic [31:0] exp_exit_q[$];

    gate_sensor_interface #(
        .DEBOUNCE_CYCLES(DB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .entry_a_raw (entry_a_raw),
        .entry_b_raw (entry_b_raw),
        .exit_a_raw  (exit_a_raw),
        .exit_b_raw  (exit_b_raw),
        .entry_passed(entry_passed),
        .exit_passed (exit_passed),
        .entry_busy  (entry_busy),
        .exit_busy   (exit_busy),
        .entry_fault (entry_fault),
        .exit_fault  (exit_fault)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    // monitor: every pulse must match the next expected cycle for its lane
    always @(negedge clk) begin
        if (entry_passed) begin
            vectors++;
            if (exp_entry_q.size() == 0) begin
                miscompares++;
                $display("FAIL entry_passed: pulse at cycle %0d, expected none", cyc);
            end else if (exp_entry_q[0] != 32'(cyc)) begin
                miscompares++;
                $display("FAIL entry_passed: pulse at cycle %0d, expected cycle %0d", cyc, exp_entry_q[0]);
                void'(exp_entry_q.pop_front());
            end else begin
                void'(exp_entry_q.pop_front());
            end
        end
        if (exit_passed) begin
            vectors++;
            if (exp_exit_q.size() == 0) begin
                miscompares++;
                $display("FAIL exit_passed: pulse at cycle %0d, expected none", cyc);
            end else if (exp_exit_q[0] != 32'(cyc)) begin
                miscompares++;
                $display("FAIL exit_passed: pulse at cycle %0d, expected cycle %0d", cyc, exp_exit_q[0]);
                void'(exp_exit_q.pop_front());
            end else begin
                void'(exp_exit_q.pop_front());
            end
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Drive just after an active edge; p is the cycle count at that moment.
    task automatic drive(input bit en, input bit ex, input logic a, input logic b, output int p);
        @(posedge clk);
        #1;
        if (en) begin
            entry_a_raw = a;
            entry_b_raw = b;
        end
        if (ex) begin
            exit_a_raw = a;
            exit_b_raw = b;
        end
        p = cyc;
    endtask

    task automatic at_cycle(input int c);
        if (cyc > c) begin
            vectors++;
            miscompares++;
            $display("FAIL at_cycle: target %0d already passed, now %0d", c, cyc);
        end
        while (cyc < c) @(negedge clk);
    endtask

    task automatic legal(input bit en, input bit ex);
        int p;
        drive(en, ex, 1'b1, 1'b0, p); hold(20);
        drive(en, ex, 1'b1, 1'b1, p); hold(20);
        drive(en, ex, 1'b0, 1'b1, p); hold(20);
        drive(en, ex, 1'b0, 1'b0, p);
        if (en) exp_entry_q.push_back(32'(p + PULSE_LAT));
        if (ex) exp_exit_q.push_back(32'(p + PULSE_LAT));
        hold(20);
    endtask

    initial begin
        int p;
        // reset with all raws high
        entry_a_raw = 1'b1; entry_b_raw = 1'b1;
        exit_a_raw  = 1'b1; exit_b_raw  = 1'b1;
        hold(5);
        @(negedge clk);
        check("rst entry_passed", entry_passed, 1'b0);
        check("rst exit_passed", exit_passed, 1'b0);
        check("rst entry_busy", entry_busy, 1'b0);
        check("rst exit_busy", exit_busy, 1'b0);
        check("rst entry_fault", entry_fault, 1'b0);
        check("rst exit_fault", exit_fault, 1'b0);
        entry_a_raw = 1'b0; entry_b_raw = 1'b0;
        exit_a_raw  = 1'b0; exit_b_raw  = 1'b0;
        reset_n = 1'b1;
        hold(20);
        @(negedge clk);
        check("idle entry_busy", entry_busy, 1'b0);
        check("idle exit_busy", exit_busy, 1'b0);

        // legal entry, then legal exit
        legal(1'b1, 1'b0);
        legal(1'b0, 1'b1);
        @(negedge clk);
        check("after legal exit_fault", exit_fault, 1'b0);

        // bounce: 3-cycle high pulses must never reach the FSM
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, p); hold(2);
            drive(1'b1, 1'b0, 1'b0, 1'b0, p); hold(2);
            @(negedge clk);
            check("bounce entry_busy", entry_busy, 1'b0);
        end
        hold(10);
        @(negedge clk);
        check("post bounce entry_busy", entry_busy, 1'b0);
        legal(1'b1, 1'b0);

        // reverse: b before a, no pulse
        drive(1'b1, 1'b0, 1'b0, 1'b1, p); hold(20);
        @(negedge clk);
        check("reverse entry_busy", entry_busy, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 1'b1, p); hold(20);
        @(negedge clk);
        check("reverse ab entry_busy", entry_busy, 1'b1);
        check("reverse entry_fault", entry_fault, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, p); hold(20);
        @(negedge clk);
        check("reverse clear entry_busy", entry_busy, 1'b0);

        // back-out: a only
        drive(1'b1, 1'b0, 1'b1, 1'b0, p); hold(20);
        @(negedge clk);
        check("backout entry_busy", entry_busy, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, p); hold(20);
        @(negedge clk);
        check("backout clear entry_busy", entry_busy, 1'b0);

        // timeout: filtered A at p+6, A_ON at p+7, FAULT 50 cycles later
        drive(1'b1, 1'b0, 1'b1, 1'b0, p);
        at_cycle(p + 2 + DB + 1 + TO - 1);
        check("pre-timeout entry_fault", entry_fault, 1'b0);
        check("pre-timeout entry_busy", entry_busy, 1'b1);
        at_cycle(p + 2 + DB + 1 + TO);
        check("timeout entry_fault", entry_fault, 1'b1);
        check("timeout exit_fault", exit_fault, 1'b0);
        at_cycle(p + 99);
        check("timeout held entry_fault", entry_fault, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, p);
        at_cycle(p + 2 + DB - 1);
        check("fault before clear", entry_fault, 1'b1);
        at_cycle(p + 2 + DB);
        check("fault cleared", entry_fault, 1'b0);
        at_cycle(p + 2 + DB + 1);
        check("fault idle entry_busy", entry_busy, 1'b0);
        hold(20);

        // simultaneous lanes: pulses land in the same cycle
        legal(1'b1, 1'b1);

        // reset mid-passage during BOTH
        drive(1'b1, 1'b1, 1'b1, 1'b0, p); hold(20);
        drive(1'b1, 1'b1, 1'b1, 1'b1, p); hold(10);
        @(negedge clk);
        check("both entry_busy", entry_busy, 1'b1);
        check("both exit_busy", exit_busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check("midrst entry_busy", entry_busy, 1'b0);
        check("midrst exit_busy", exit_busy, 1'b0);
        check("midrst entry_passed", entry_passed, 1'b0);
        check("midrst exit_passed", exit_passed, 1'b0);
        entry_a_raw = 1'b0; entry_b_raw = 1'b0;
        exit_a_raw  = 1'b0; exit_b_raw  = 1'b0;
        hold(3);
        @(negedge clk);
        reset_n = 1'b1;
        hold(20);
        @(negedge clk);
        check("post midrst entry_busy", entry_busy, 1'b0);
        check("post midrst exit_busy", exit_busy, 1'b0);

        // one more clean pair to prove the lanes recover
        legal(1'b1, 1'b1);
        hold(5);

        vectors++;
        if (exp_entry_q.size() != 0) begin
            miscompares++;
            $display("FAIL entry pulses missing: %0d outstanding, expected 0", exp_entry_q.size());
        end
        vectors++;
        if (exp_exit_q.size() != 0) begin
            miscompares++;
            $display("FAIL exit pulses missing: %0d outstanding, expected 0", exp_exit_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/gate_sensor_interface.md
Name: gate_sensor_interface

Overview:
- Upstream stage of the vehicle counter. Takes raw, asynchronous, bouncy beam-sensor levels from an entry lane and an exit lane. Each lane has two beams, A then B, in the legal travel direction.
- Per lane: synchronises, debounces and sequence-checks the beams. Emits one single-cycle entry_passed / exit_passed pulse per completed legal passage, for direct connection to the counter.
- Also flags reverse travel, backing out, and stuck-sensor timeouts. None of these produce a pulse.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised cycles required before a filtered sensor level changes (1..255).
- TIMEOUT_CYCLES, 1000, maximum cycles a lane may stay in one non-IDLE state before faulting (1..65535).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous reset, active low
- entry_a_raw  input  1  entry lane outer beam, 1 = blocked, asynchronous
- entry_b_raw  input  1  entry lane inner beam, 1 = blocked, asynchronous
- exit_a_raw  input  1  exit lane inside beam, 1 = blocked, asynchronous
- exit_b_raw  input  1  exit lane outside beam, 1 = blocked, asynchronous
- entry_passed  output  1  one-cycle pulse, legal entry completed
- exit_passed  output  1  one-cycle pulse, legal exit completed
- entry_busy  output  1  entry lane FSM not in IDLE
- exit_busy  output  1  exit lane FSM not in IDLE
- entry_fault  output  1  entry lane in FAULT (timeout)
- exit_fault  output  1  exit lane in FAULT (timeout)

Behaviour:
- One clock. Reset is asynchronous and active-low on reset_n.
- Reset clears: all synchronisers, filtered levels, debounce counters and timeout counters to 0; both FSMs to IDLE; all outputs to 0.
- Reset may assert mid-passage. The passage is discarded with no pulse.
- Both lanes are identical, independent instances of the logic below. Simultaneous events on both lanes are fully independent; both pulses may assert in the same cycle.

Input conditioning (per raw input):
- 2-flop synchroniser.
- 8-bit debounce counter. It clears whenever the synchronised value equals the filtered value; otherwise it increments.
- When the counter reaches DEBOUNCE_CYCLES, the filtered value takes the synchronised value and the counter clears.
- Glitches shorter than DEBOUNCE_CYCLES never reach the FSM.
- Raw edge to filtered edge latency is 2 + DEBOUNCE_CYCLES cycles.

Lane FSM (A, B = filtered levels), states IDLE, A_ON, BOTH, B_ONLY, REVERSE, FAULT:
- IDLE:
  - A & !B -> A_ON
  - B (any A) -> REVERSE
- A_ON:
  - A & B -> BOTH
  - !A & B -> B_ONLY
  - !A & !B -> IDLE (backed out, no pulse)
- BOTH:
  - !A & B -> B_ONLY
  - A & !B -> A_ON
  - !A & !B -> IDLE (no pulse)
- B_ONLY:
  - !A & !B -> IDLE, and assert passed
  - A & B -> BOTH
  - A & !B -> A_ON
- REVERSE:
  - !A & !B -> IDLE (no pulse)
- FAULT:
  - fault = 1 while in this state
  - !A & !B -> IDLE; fault clears in the same cycle as the IDLE transition
- Timeout: a 16-bit timeout counter clears on every state change and while in IDLE or FAULT. It increments every cycle otherwise. Reaching TIMEOUT_CYCLES forces FAULT from A_ON, BOTH, B_ONLY or REVERSE.
- passed is a registered output. It is high exactly one cycle, in the cycle after the filtered levels show B_ONLY with both beams clear. Back-to-back passages can therefore never merge into one pulse.
- busy = (state != IDLE). It is registered, from the state register.

Test Plan (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=50):
- Reset: reset_n low with all raw inputs high -> all outputs 0. Release reset, drop raws to 0, hold 20 cycles -> no pulses, busy = 0.
- Legal entry: entry_a high, then entry_b high 20 cycles later, then a low, then b low, each level held 20 cycles -> exactly one entry_passed pulse, 7 cycles (2 + 4 + registered output) after the final raw b fall. exit outputs stay 0. Same sequence on the exit lane -> one exit_passed pulse.
- Bounce: entry_a toggling with 3-cycle pulses for 40 cycles, then a clean legal sequence -> filtered A never changes during the bounce; exactly one entry_passed pulse for the clean sequence.
- Reverse and back-out: entry_b before a, then both clear -> passes through REVERSE, no pulse. Separately, a high then a low with b never set -> A_ON then IDLE, no pulse.
- Timeout: entry_a held high 100 cycles -> entry_fault asserts once 50 cycles have elapsed in A_ON. Then clear a -> fault deasserts 6 cycles after the raw fall, and no pulse is produced.
- Simultaneous lanes with reset mid-passage: identical legal sequences on both lanes in lockstep -> entry_passed and exit_passed pulse in the same cycle. Repeat with reset_n pulsed low during BOTH -> no pulse, both busy = 0 immediately.
